mm_tile_job_scheduler: RTL and testbench
========================================

// Module: mm_tile_job_scheduler
// PURPOSE
//  Sequences tiled matrix-multiply work (C = A x B, square N x N, row-major) for the cu_mmtiled
//  compute unit. Latches the decoded WED fields (size_n, size_tile, Matrix_A/B/C) and walks tile
//  indices i (outer), j (middle), k (inner). Emits one tile job descriptor per (i,j,k) on a
//  valid/ready port and throttles issue by an outstanding-job credit limit. Sits between WED
//  control and the tile read/compute/write engines.
// PARAMETERS
//  ELEM_BYTES       4   bytes per matrix element (address scaling)
//  IDX_W            32  width of tile index outputs and job counters
//  MAX_OUTSTANDING  4   max jobs issued but not yet reported done (1..255)
// PORTS
//  clock             in   1      clock
//  reset             in   1      synchronous, active-high reset
//  enabled_in        in   1      gates job start and new issue
//  wed_valid_in      in   1      1-cycle pulse: WED fields below are valid
//  wed_size_n_in     in   64     N (elements per row/col)
//  wed_size_tile_in  in   64     T (tile edge, elements)
//  wed_matrix_a_in   in   64     base address A
//  wed_matrix_b_in   in   64     base address B
//  wed_matrix_c_in   in   64     base address C
//  job_valid_out     out  1      descriptor valid
//  job_ready_in      in   1      consumer accepts descriptor
//  job_a_addr_out    out  64     A tile addr = A + (i*T*N + k*T)*ELEM_BYTES
//  job_b_addr_out    out  64     B tile addr = B + (k*T*N + j*T)*ELEM_BYTES
//  job_c_addr_out    out  64     C tile addr = C + (i*T*N + j*T)*ELEM_BYTES
//  job_i_out/j/k     out  IDX_W  tile indices (three ports)
//  job_first_k_out   out  1      k==0 (consumer zeroes accumulator)
//  job_last_k_out    out  1      last k (consumer writes C tile back)
//  job_done_in       in   1      1-cycle pulse: one issued job retired
//  busy_out          out  1      state not IDLE/DONE/ERROR
//  done_out          out  1      all jobs issued and retired
//  error_out         out  1      sticky config/protocol error
//  jobs_issued_out   out  IDX_W  accepted descriptors
//  jobs_done_out     out  IDX_W  retired jobs
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters, credits, pointers, index registers cleared.
//    Reset mid-job abandons the job immediately, with no drain.
//  Tile count: ceil(N/T) per dimension with no divider. Per dimension, track element offset
//    e (+=T per step); the index is last when e+T >= N. T > N gives 1 tile per dimension.
//  Pointers: computed incrementally with adders only. SETUP precomputes:
//    row_step = T*N*ELEM_BYTES and col_step = T*ELEM_BYTES (registered multiply, 2 cycles).
//    k step: a += col_step; b += row_step.
//    j step: b = B + j*col_step; c += col_step.
//    i step: row pointers += row_step.
//  FSM:
//    IDLE  : wed_valid_in && enabled_in -> SETUP; latch fields.
//            N==0 or T==0 -> ERROR instead.
//    SETUP : 2 cycles; load i=j=k=0 pointers -> ISSUE.
//    ISSUE : job_valid_out=1 when enabled_in && outstanding<MAX_OUTSTANDING.
//            Once asserted, valid and payload hold stable until job_valid_out&&job_ready_in.
//            On accept: outstanding++, jobs_issued++, advance k, then j, then i.
//            Last (i,j,k) accepted -> DRAIN.
//    DRAIN : wait outstanding==0 -> DONE.
//    DONE  : done_out=1 held; wed_valid_in && enabled_in -> SETUP (done_out cleared, counters reset).
//    ERROR : error_out=1 held until reset.
//  enabled_in low: no new valid raised, but an already-raised valid stays up (no retraction).
//  Credits: accept and job_done_in in the same cycle leave outstanding unchanged.
//    job_done_in with outstanding==0 is ignored for counting and sets error_out (sticky),
//    with no state change.
//  wed_valid_in outside IDLE/DONE is ignored.
//  Job issue latency: first job_valid_out 3 cycles after the accepted wed_valid_in.
//    Back-to-back accepts at 1 job/cycle when credits allow.
// TESTING
//  T1 N=4,T=2,A=0x1000,B=0x2000,C=0x3000,ready=1,done echoed: 8 jobs.
//     Job0: A=0x1000 B=0x2000 C=0x3000, ijk=000, first_k=1, last_k=0.
//     Job1: A=0x1008 B=0x2020 C=0x3000, last_k=1.
//     Then done_out=1, jobs_done_out=8.
//  T2 N=5,T=2, same bases: 27 jobs. Last job ijk=222: A=0x1060, B=0x2060, C=0x3060.
//  T3 T=0 (or N=0) -> ERROR within 1 cycle, error_out=1, job_valid_out never asserts.
//  T4 job_ready_in low 10 cycles mid-stream -> valid and all payload bits stable;
//     no skipped or duplicated (i,j,k).
//  T5 MAX_OUTSTANDING=4, no job_done_in -> exactly 4 accepts, then valid low.
//     One done pulse -> exactly one more accept. Simultaneous accept+done -> outstanding unchanged.
//  T6 reset asserted during ISSUE with job_valid_out=1 -> next cycle all outputs 0, state IDLE.
//     Spurious job_done_in in IDLE -> error_out=1.

Source files
------------

// File: rtl/mm_tile_job_scheduler.sv
// Tile job scheduler: walks (i,j,k) tiles of C = A x B and issues address descriptors under a credit limit.
// Latency: first descriptor 3 cycles after WED; backpressure: valid/payload hold until ready, issue stalls at credit limit.
module mm_tile_job_scheduler #(
   parameter int ELEM_BYTES      = 4,
   parameter int IDX_W           = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enabled_in,
   input  logic             wed_valid_in,
   input  logic [63:0]      wed_size_n_in,
   input  logic [63:0]      wed_size_tile_in,
   input  logic [63:0]      wed_matrix_a_in,
   input  logic [63:0]      wed_matrix_b_in,
   input  logic [63:0]      wed_matrix_c_in,
   output logic             job_valid_out,
   input  logic             job_ready_in,
   output logic [63:0]      job_a_addr_out,
   output logic [63:0]      job_b_addr_out,
   output logic [63:0]      job_c_addr_out,
   output logic [IDX_W-1:0] job_i_out,
   output logic [IDX_W-1:0] job_j_out,
   output logic [IDX_W-1:0] job_k_out,
   output logic             job_first_k_out,
   output logic             job_last_k_out,
   input  logic             job_done_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             error_out,
   output logic [IDX_W-1:0] jobs_issued_out,
   output logic [IDX_W-1:0] jobs_done_out
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP1, S_SETUP2, S_ISSUE, S_DRAIN, S_DONE, S_ERROR} state_t;

   localparam logic [63:0] EB      = 64'(ELEM_BYTES);
   localparam logic [7:0]  MAX_OUT = 8'(MAX_OUTSTANDING);

   state_t           state_q;
   logic [63:0]      n_q, t_q, a_base_q, b_base_q, c_base_q;
   logic [63:0]      tn_q, col_step_q, row_step_q;
   logic [64:0]      endi_q, endj_q, endk_q;
   logic [63:0]      a_row_q, b_col_q, c_row_q, a_q, b_q, c_q;
   logic [IDX_W-1:0] i_q, j_q, k_q, issued_q, retired_q;
   logic             first_k_q, last_k_q, valid_q, error_q;
   logic [7:0]       outst_q;

   logic             accept, done_ok, last_i, last_j, last_k, can_issue;
   logic [7:0]       outst_d;
   logic [64:0]      t_ext, n_ext, endi_d, endj_d, endk_d;
   logic [63:0]      a_row_d, b_col_d, c_row_d, a_d, b_d, c_d;
   logic [IDX_W-1:0] i_d, j_d, k_d;

   // Tile end offsets are one bit wider than N so e+T never wraps.
   assign t_ext   = {1'b0, t_q};
   assign n_ext   = {1'b0, n_q};
   assign last_k  = endk_q >= n_ext;
   assign last_j  = endj_q >= n_ext;
   assign last_i  = endi_q >= n_ext;
   assign accept  = valid_q & job_ready_in;
   assign done_ok = job_done_in & (outst_q != 8'd0);

   always_comb begin
      outst_d = outst_q;
      if (accept && !done_ok)
         outst_d = outst_q + 8'd1;
      else if (!accept && done_ok)
         outst_d = outst_q - 8'd1;
   end

   assign can_issue = enabled_in && (outst_d < MAX_OUT);

   always_comb begin
      i_d = i_q;  j_d = j_q;  k_d = k_q;
      endi_d = endi_q;  endj_d = endj_q;  endk_d = endk_q;
      a_row_d = a_row_q;  b_col_d = b_col_q;  c_row_d = c_row_q;
      a_d = a_q;  b_d = b_q;  c_d = c_q;
      if (!last_k) begin
         k_d    = k_q + IDX_W'(1);
         endk_d = endk_q + t_ext;
         a_d    = a_q + col_step_q;
         b_d    = b_q + row_step_q;
      end else begin
         k_d    = '0;
         endk_d = t_ext;
         if (!last_j) begin
            j_d     = j_q + IDX_W'(1);
            endj_d  = endj_q + t_ext;
            b_col_d = b_col_q + col_step_q;
            a_d     = a_row_q;
            b_d     = b_col_d;
            c_d     = c_q + col_step_q;
         end else begin
            j_d     = '0;
            endj_d  = t_ext;
            b_col_d = b_base_q;
            i_d     = i_q + IDX_W'(1);
            endi_d  = endi_q + t_ext;
            a_row_d = a_row_q + row_step_q;
            c_row_d = c_row_q + row_step_q;
            a_d     = a_row_d;
            b_d     = b_base_q;
            c_d     = c_row_d;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q <= '0;  t_q <= '0;  a_base_q <= '0;  b_base_q <= '0;  c_base_q <= '0;
         tn_q <= '0;  col_step_q <= '0;  row_step_q <= '0;
         endi_q <= '0;  endj_q <= '0;  endk_q <= '0;
         a_row_q <= '0;  b_col_q <= '0;  c_row_q <= '0;
         a_q <= '0;  b_q <= '0;  c_q <= '0;
         i_q <= '0;  j_q <= '0;  k_q <= '0;
         issued_q <= '0;  retired_q <= '0;  outst_q <= '0;
         first_k_q <= 1'b0;  last_k_q <= 1'b0;  valid_q <= 1'b0;  error_q <= 1'b0;
      end else begin
         outst_q <= outst_d;
         if (done_ok)
            retired_q <= retired_q + IDX_W'(1);
         if (job_done_in && outst_q == 8'd0)
            error_q <= 1'b1;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (wed_valid_in && enabled_in) begin
                  n_q       <= wed_size_n_in;
                  t_q       <= wed_size_tile_in;
                  a_base_q  <= wed_matrix_a_in;
                  b_base_q  <= wed_matrix_b_in;
                  c_base_q  <= wed_matrix_c_in;
                  issued_q  <= '0;
                  retired_q <= '0;
                  if (wed_size_n_in == 64'd0 || wed_size_tile_in == 64'd0) begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= S_SETUP1;
                  end
               end
            end
            S_SETUP1: begin
               tn_q       <= t_q * n_q;
               col_step_q <= t_q * EB;
               state_q    <= S_SETUP2;
            end
            S_SETUP2: begin
               row_step_q <= tn_q * EB;
               i_q <= '0;  j_q <= '0;  k_q <= '0;
               endi_q <= t_ext;  endj_q <= t_ext;  endk_q <= t_ext;
               a_row_q <= a_base_q;  b_col_q <= b_base_q;  c_row_q <= c_base_q;
               a_q <= a_base_q;  b_q <= b_base_q;  c_q <= c_base_q;
               first_k_q <= 1'b1;
               last_k_q  <= t_ext >= n_ext;
               valid_q   <= can_issue;
               state_q   <= S_ISSUE;
            end
            S_ISSUE: begin
               if (accept) begin
                  issued_q <= issued_q + IDX_W'(1);
                  i_q <= i_d;  j_q <= j_d;  k_q <= k_d;
                  endi_q <= endi_d;  endj_q <= endj_d;  endk_q <= endk_d;
                  a_row_q <= a_row_d;  b_col_q <= b_col_d;  c_row_q <= c_row_d;
                  a_q <= a_d;  b_q <= b_d;  c_q <= c_d;
                  first_k_q <= last_k;
                  last_k_q  <= endk_d >= n_ext;
                  if (last_i && last_j && last_k) begin
                     valid_q <= 1'b0;
                     state_q <= S_DRAIN;
                  end else begin
                     valid_q <= can_issue;
                  end
               end else if (!valid_q) begin
                  valid_q <= can_issue;
               end
            end
            S_DRAIN: begin
               if (outst_q == 8'd0)
                  state_q <= S_DONE;
            end
            default: error_q <= 1'b1;
         endcase
      end
   end

   assign job_valid_out   = valid_q;
   assign job_a_addr_out  = a_q;
   assign job_b_addr_out  = b_q;
   assign job_c_addr_out  = c_q;
   assign job_i_out       = i_q;
   assign job_j_out       = j_q;
   assign job_k_out       = k_q;
   assign job_first_k_out = first_k_q;
   assign job_last_k_out  = last_k_q;
   assign busy_out        = (state_q == S_SETUP1) || (state_q == S_SETUP2) ||
                            (state_q == S_ISSUE)  || (state_q == S_DRAIN);
   assign done_out        = state_q == S_DONE;
   assign error_out       = error_q;
   assign jobs_issued_out = issued_q;
   assign jobs_done_out   = retired_q;

endmodule

// File: tb/tb_mm_tile_job_scheduler.sv
// Bench for mm_tile_job_scheduler: expected descriptors queued at stimulus time, popped by a negedge monitor.
module tb_mm_tile_job_scheduler;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enabled_in = 1'b0;
   logic        wed_valid_in = 1'b0;
   logic [63:0] wed_size_n_in = '0, wed_size_tile_in = '0;
   logic [63:0] wed_matrix_a_in = '0, wed_matrix_b_in = '0, wed_matrix_c_in = '0;
   logic        job_ready_in = 1'b0;
   logic        echo_done = 1'b0, man_done = 1'b0, echo_en = 1'b0;
   logic        job_done_in;
   logic        job_valid_out, job_first_k_out, job_last_k_out, busy_out, done_out, error_out;
   logic [63:0] job_a_addr_out, job_b_addr_out, job_c_addr_out;
   logic [31:0] job_i_out, job_j_out, job_k_out, jobs_issued_out, jobs_done_out;

   assign job_done_in = echo_done | man_done;

   mm_tile_job_scheduler #(.ELEM_BYTES(4), .IDX_W(32), .MAX_OUTSTANDING(4)) dut (
      .clock(clock), .reset(reset), .enabled_in(enabled_in), .wed_valid_in(wed_valid_in),
      .wed_size_n_in(wed_size_n_in), .wed_size_tile_in(wed_size_tile_in),
      .wed_matrix_a_in(wed_matrix_a_in), .wed_matrix_b_in(wed_matrix_b_in),
      .wed_matrix_c_in(wed_matrix_c_in), .job_valid_out(job_valid_out), .job_ready_in(job_ready_in),
      .job_a_addr_out(job_a_addr_out), .job_b_addr_out(job_b_addr_out), .job_c_addr_out(job_c_addr_out),
      .job_i_out(job_i_out), .job_j_out(job_j_out), .job_k_out(job_k_out),
      .job_first_k_out(job_first_k_out), .job_last_k_out(job_last_k_out), .job_done_in(job_done_in),
      .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
      .jobs_issued_out(jobs_issued_out), .jobs_done_out(jobs_done_out)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [63:0] a, b, c;
      logic [31:0] i, j, k;
      logic        fk, lk;
   } job_t;

   job_t exp_q[$];
   job_t seen_q[$];
   int   checks = 0, failures = 0;
   int   acc_count = 0, echo_count = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_ctl"}, 64'({job_valid_out, job_first_k_out, job_last_k_out, busy_out, done_out, error_out}), 64'd0);
      chk({p, "_addr"}, job_a_addr_out | job_b_addr_out | job_c_addr_out, 64'd0);
      chk({p, "_ij"}, {job_i_out, job_j_out}, 64'd0);
      chk({p, "_k"}, 64'(job_k_out), 64'd0);
      chk({p, "_cnt"}, {jobs_issued_out, jobs_done_out}, 64'd0);
   endtask

   // Reference model uses closed-form tile addresses, independent of the incremental datapath.
   task automatic push_jobs(input longint unsigned n, t, a, b, c);
      longint unsigned tl;
      job_t e;
      tl = (n + t - 1) / t;
      for (longint unsigned i = 0; i < tl; i++)
         for (longint unsigned j = 0; j < tl; j++)
            for (longint unsigned k = 0; k < tl; k++) begin
               e.a  = a + (i * t * n + k * t) * 4;
               e.b  = b + (k * t * n + j * t) * 4;
               e.c  = c + (i * t * n + j * t) * 4;
               e.i  = 32'(i);
               e.j  = 32'(j);
               e.k  = 32'(k);
               e.fk = (k == 0);
               e.lk = (k == tl - 1);
               exp_q.push_back(e);
            end
   endtask

   task automatic start_job(input logic [63:0] n, t, a, b, c);
      @(posedge clock); #1;
      wed_size_n_in = n;  wed_size_tile_in = t;
      wed_matrix_a_in = a;  wed_matrix_b_in = b;  wed_matrix_c_in = c;
      wed_valid_in = 1'b1;
      @(posedge clock); #1;
      wed_valid_in = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int c = 0;
      while (!done_out && c < budget) begin
         @(negedge clock);
         c++;
      end
      chk(nm, 64'(done_out), 64'd1);
   endtask

   // Monitor: pops the scoreboard on every handshake and checks hold-stability while stalled.
   initial begin : monitor
      job_t got, held, e;
      logic hold;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clock);
         got.a = job_a_addr_out;  got.b = job_b_addr_out;  got.c = job_c_addr_out;
         got.i = job_i_out;  got.j = job_j_out;  got.k = job_k_out;
         got.fk = job_first_k_out;  got.lk = job_last_k_out;
         if (reset) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("hold_valid", 64'(job_valid_out), 64'd1);
               chk("hold_payload", 64'(got == held), 64'd1);
            end
            if (job_valid_out && job_ready_in) begin
               acc_count++;
               seen_q.push_back(got);
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_job: actual ijk=%0d/%0d/%0d required none", got.i, got.j, got.k);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     failures++;
                     $display("FAIL job_desc: actual ijk=%0d/%0d/%0d a=%h b=%h c=%h fk=%b lk=%b required ijk=%0d/%0d/%0d a=%h b=%h c=%h fk=%b lk=%b",
                              got.i, got.j, got.k, got.a, got.b, got.c, got.fk, got.lk,
                              e.i, e.j, e.k, e.a, e.b, e.c, e.fk, e.lk);
                  end
               end
            end
            hold = job_valid_out && !job_ready_in;
            held = got;
         end
      end
   end

   // Retire each accepted job one cycle later while echoing is enabled.
   initial begin : echo
      forever begin
         @(posedge clock); #1;
         if (echo_en && acc_count != echo_count) begin
            echo_done = 1'b1;
            echo_count++;
         end else begin
            echo_done = 1'b0;
            if (!echo_en) echo_count = acc_count;
         end
      end
   end

   initial begin : watchdog
      #100000;
      failures++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : main
      int   base, c;
      job_t l;

      cycles(3);
      @(negedge clock);
      chk_zero("reset");
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk_zero("post_reset");

      // T1: N=4, T=2
      enabled_in = 1'b1;  job_ready_in = 1'b1;  echo_en = 1'b1;
      base = seen_q.size();
      push_jobs(4, 2, 64'h1000, 64'h2000, 64'h3000);
      start_job(4, 2, 64'h1000, 64'h2000, 64'h3000);
      @(negedge clock); chk("t1_lat_c1", 64'(job_valid_out), 64'd0);
      @(negedge clock); chk("t1_lat_c2", 64'(job_valid_out), 64'd0);
      @(negedge clock); chk("t1_lat_c3", 64'(job_valid_out), 64'd1);
      wait_done("t1_done", 100);
      chk("t1_retired", 64'(jobs_done_out), 64'd8);
      chk("t1_issued", 64'(jobs_issued_out), 64'd8);
      chk("t1_busy", 64'(busy_out), 64'd0);
      chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
      l = seen_q[base];
      chk("t1_j0_a", l.a, 64'h1000);
      chk("t1_j0_b", l.b, 64'h2000);
      chk("t1_j0_c", l.c, 64'h3000);
      chk("t1_j0_flags", 64'({l.i, l.j, l.k, l.fk, l.lk}), 64'b10);
      l = seen_q[base + 1];
      chk("t1_j1_a", l.a, 64'h1008);
      chk("t1_j1_b", l.b, 64'h2020);
      chk("t1_j1_c", l.c, 64'h3000);
      chk("t1_j1_flags", 64'({l.fk, l.lk}), 64'b01);

      // T2: N=5, T=2 -> 3 tiles per dimension
      base = seen_q.size();
      push_jobs(5, 2, 64'h1000, 64'h2000, 64'h3000);
      start_job(5, 2, 64'h1000, 64'h2000, 64'h3000);
      wait_done("t2_done", 300);
      chk("t2_retired", 64'(jobs_done_out), 64'd27);
      chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
      l = seen_q[base + 26];
      chk("t2_last_ij", {l.i, l.j}, {32'd2, 32'd2});
      chk("t2_last_k", 64'(l.k), 64'd2);
      chk("t2_last_a", l.a, 64'h1060);
      chk("t2_last_b", l.b, 64'h2060);
      chk("t2_last_c", l.c, 64'h3060);

      // T4: ready stalled mid-stream
      push_jobs(4, 2, 64'h1000, 64'h2000, 64'h3000);
      start_job(4, 2, 64'h1000, 64'h2000, 64'h3000);
      c = 0;
      while (jobs_issued_out != 32'd2 && c < 50) begin
         @(negedge clock);
         c++;
      end
      chk("t4_reach2", 64'(jobs_issued_out), 64'd2);
      @(posedge clock); #1;
      job_ready_in = 1'b0;
      cycles(10);
      @(negedge clock);
      chk("t4_stall_issued", 64'(jobs_issued_out), 64'd3);
      chk("t4_stall_valid", 64'(job_valid_out), 64'd1);
      @(posedge clock); #1;
      job_ready_in = 1'b1;
      wait_done("t4_done", 100);
      chk("t4_issued", 64'(jobs_issued_out), 64'd8);
      chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

      // T3: zero tile and zero size go to ERROR
      start_job(4, 0, 64'h1000, 64'h2000, 64'h3000);
      @(negedge clock);
      chk("t3_err_t0", 64'(error_out), 64'd1);
      chk("t3_busy_t0", 64'(busy_out), 64'd0);
      cycles(5);
      @(negedge clock);
      chk("t3_valid_t0", 64'(job_valid_out), 64'd0);
      chk("t3_sticky_t0", 64'(error_out), 64'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      @(negedge clock);
      chk("t3_err_clr", 64'(error_out), 64'd0);
      start_job(0, 2, 64'h1000, 64'h2000, 64'h3000);
      @(negedge clock);
      chk("t3_err_n0", 64'(error_out), 64'd1);
      chk("t3_valid_n0", 64'(job_valid_out), 64'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;

      // T5: credit limit with manual retirement
      echo_en = 1'b0;
      push_jobs(4, 2, 64'h1000, 64'h2000, 64'h3000);
      start_job(4, 2, 64'h1000, 64'h2000, 64'h3000);
      cycles(12);
      @(negedge clock);
      chk("t5_cap_issued", 64'(jobs_issued_out), 64'd4);
      chk("t5_cap_valid", 64'(job_valid_out), 64'd0);
      @(posedge clock); #1; man_done = 1'b1;
      @(posedge clock); #1; man_done = 1'b0;
      cycles(5);
      @(negedge clock);
      chk("t5_one_more", 64'(jobs_issued_out), 64'd5);
      chk("t5_one_valid", 64'(job_valid_out), 64'd0);
      chk("t5_one_retired", 64'(jobs_done_out), 64'd1);
      @(posedge clock); #1; job_ready_in = 1'b0; man_done = 1'b1;
      @(posedge clock); #1; job_ready_in = 1'b1; man_done = 1'b1;
      @(posedge clock); #1; job_ready_in = 1'b0; man_done = 1'b0;
      @(negedge clock);
      chk("t5_simul_issued", 64'(jobs_issued_out), 64'd6);
      chk("t5_simul_valid", 64'(job_valid_out), 64'd1);
      chk("t5_simul_retired", 64'(jobs_done_out), 64'd3);
      @(posedge clock); #1; job_ready_in = 1'b1;
      @(posedge clock); #1; job_ready_in = 1'b0;
      cycles(3);
      @(negedge clock);
      chk("t5_refill_issued", 64'(jobs_issued_out), 64'd7);
      chk("t5_refill_valid", 64'(job_valid_out), 64'd0);

      // T6: reset while a descriptor is held, then spurious retire in IDLE
      @(posedge clock); #1; man_done = 1'b1;
      @(posedge clock); #1; man_done = 1'b0;
      @(negedge clock);
      chk("t6_pre_valid", 64'(job_valid_out), 64'd1);
      chk("t6_pre_lastk", 64'(job_last_k_out), 64'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk_zero("t6_reset");
      chk("t6_sb_left", 64'(exp_q.size()), 64'd1);
      exp_q.delete();
      @(posedge clock); #1; reset = 1'b0;
      @(posedge clock); #1; man_done = 1'b1;
      @(posedge clock); #1; man_done = 1'b0;
      @(negedge clock);
      chk("t6_spur_err", 64'(error_out), 64'd1);
      chk("t6_spur_state", 64'({busy_out, done_out, job_valid_out}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
